// File: rtl/ni_read_scheduler.sv
`default_nettype none
// ni_read_scheduler: round-robin read controller draining the per-app NI FIFO bank into one core stream.
// Rev 1.0
module ni_read_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int APP_ID_BITS = 2,
  parameter int BURST_MAX   = 4,
  parameter int CNT_BITS    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ON,
  input  logic [2**APP_ID_BITS-1:0]  app_enable,
  input  logic                       ni_empty,
  input  logic [DATA_WIDTH-1:0]      ni_read_data,
  output logic [APP_ID_BITS-1:0]     ni_DEMUX,
  output logic                       ni_rdEn,
  input  logic                       core_ready,
  output logic                       core_valid,
  output logic [DATA_WIDTH-1:0]      core_data,
  output logic [APP_ID_BITS-1:0]     core_app_id,
  output logic                       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [CNT_BITS-1:0] BURST_LIM = CNT_BITS'(BURST_MAX);

  logic [1:0]             state, state_next;
  logic [APP_ID_BITS-1:0] ptr, ptr_next;
  logic [CNT_BITS-1:0]    cnt, cnt_next;
  logic                   valid_q;
  logic [APP_ID_BITS-1:0] app_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      valid_q  <= 1'b0;
      app_id_q <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      valid_q  <= ni_rdEn;
      app_id_q <= ptr;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ON && (app_enable != '0))
          state_next = SCAN;
      end
      SCAN: begin
        if (!ON)
          state_next = IDLE;
        else if (app_enable[ptr] && !ni_empty) begin
          state_next = READ;
          cnt_next   = '0;
        end else if (app_enable == '0)
          state_next = IDLE;
        else
          ptr_next = ptr + 1'b1;
      end
      READ: begin
        // A read issued last cycle still returns data; DRAIN keeps DEMUX stable for it.
        if (!ON)
          state_next = valid_q ? DRAIN : IDLE;
        else if (ni_rdEn) begin
          cnt_next = cnt + 1'b1;
          if (cnt_next == BURST_LIM)
            state_next = DRAIN;
        end else if (ni_empty || !app_enable[ptr] || (cnt >= BURST_LIM))
          state_next = DRAIN;
      end
      DRAIN: begin
        ptr_next   = ptr + 1'b1;
        state_next = ON ? SCAN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ni_rdEn = (state == READ) && ON && core_ready && !ni_empty &&
              app_enable[ptr] && (cnt < BURST_LIM);
    busy    = (state != IDLE);
  end

  assign ni_DEMUX    = ptr;
  assign core_valid  = valid_q;
  assign core_app_id = app_id_q;
  assign core_data   = valid_q ? ni_read_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_ni_read_scheduler.sv
`default_nettype none
// tb_ni_read_scheduler: directed bench with a behavioural NI FIFO bank model.
module tb_ni_read_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ON = 1'b0;
  logic [3:0]  app_enable = 4'b0000;
  logic        ni_empty;
  logic [15:0] ni_read_data = 16'h0;
  logic [1:0]  ni_DEMUX;
  logic        ni_rdEn;
  logic        core_ready = 1'b1;
  logic        core_valid;
  logic [15:0] core_data;
  logic [1:0]  core_app_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ni_read_scheduler #(.DATA_WIDTH(16), .APP_ID_BITS(2), .BURST_MAX(4), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .ON(ON), .app_enable(app_enable),
    .ni_empty(ni_empty), .ni_read_data(ni_read_data),
    .ni_DEMUX(ni_DEMUX), .ni_rdEn(ni_rdEn), .core_ready(core_ready),
    .core_valid(core_valid), .core_data(core_data), .core_app_id(core_app_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // NI FIFO bank model: empty is combinational from DEMUX, data returns the cycle after rdEn.
  logic [15:0] mem [4][16];
  int head [4];
  int tail [4];

  assign ni_empty = (head[ni_DEMUX] == tail[ni_DEMUX]);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) head[i] <= 0;
    end else if (ni_rdEn) begin
      ni_read_data      <= mem[ni_DEMUX][head[ni_DEMUX]];
      head[ni_DEMUX]    <= head[ni_DEMUX] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Delivered-word log and DEMUX stability monitor, sampled mid-cycle.
  logic [17:0] log_q [64];
  int n = 0;
  logic       prev_rd = 1'b0;
  logic [1:0] prev_dmx = 2'd0;

  always @(negedge clk) begin
    if (prev_rd) chk("demux_hold", {30'd0, ni_DEMUX}, {30'd0, prev_dmx});
    if (core_valid && !reset && n < 64) begin
      log_q[n] = {core_app_id, core_data};
      n = n + 1;
    end
    prev_rd  = ni_rdEn && !reset;
    prev_dmx = ni_DEMUX;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [15:0] d);
    mem[a][tail[a]] = d;
    tail[a] = tail[a] + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ON = 1'b0;
    app_enable = 4'b0000;
    core_ready = 1'b1;
    for (int i = 0; i < 4; i++) tail[i] = 0;
    tick();
    tick();
  endtask

  task automatic wait_rd(input string tag);
    for (int i = 0; i < 20 && !ni_rdEn; i++) tick();
    chk(tag, {31'd0, ni_rdEn}, 32'd1);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end

    // Test 1: reset values, then app0 with three words.
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rden", {31'd0, ni_rdEn}, 32'd0);
    chk("rst_demux", {30'd0, ni_DEMUX}, 32'd0);
    chk("rst_cvalid", {31'd0, core_valid}, 32'd0);
    chk("rst_cdata", {16'd0, core_data}, 32'd0);
    chk("rst_appid", {30'd0, core_app_id}, 32'd0);
    push(0, 16'hA1); push(0, 16'hA2); push(0, 16'hA3);
    reset = 1'b0; ON = 1'b1; app_enable = 4'b1001;
    tick();
    chk("t1_scan_busy", {31'd0, busy}, 32'd1);
    chk("t1_scan_rden", {31'd0, ni_rdEn}, 32'd0);
    tick();
    chk("t1_rd1", {31'd0, ni_rdEn}, 32'd1);
    chk("t1_rd1_dmx", {30'd0, ni_DEMUX}, 32'd0);
    tick();
    chk("t1_rd2", {31'd0, ni_rdEn}, 32'd1);
    chk("t1_w1", {14'd0, core_app_id, core_data}, 32'h000A1);
    chk("t1_w1_valid", {31'd0, core_valid}, 32'd1);
    tick();
    chk("t1_rd3", {31'd0, ni_rdEn}, 32'd1);
    chk("t1_w2", {14'd0, core_app_id, core_data}, 32'h000A2);
    tick();
    chk("t1_empty_rden", {31'd0, ni_rdEn}, 32'd0);
    chk("t1_w3", {14'd0, core_app_id, core_data}, 32'h000A3);
    chk("t1_w3_valid", {31'd0, core_valid}, 32'd1);
    tick();
    chk("t1_drain_valid", {31'd0, core_valid}, 32'd0);
    chk("t1_drain_dmx", {30'd0, ni_DEMUX}, 32'd0);
    chk("t1_drain_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t1_scan_dmx", {30'd0, ni_DEMUX}, k % 4);
      chk("t1_scan_nord", {31'd0, ni_rdEn}, 32'd0);
    end
    chk("t1_scan_busy2", {31'd0, busy}, 32'd1);

    // Test 2: burst limit interleaving app0 and app3.
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 16'hB0 + 16'(k));
    push(3, 16'hC0); push(3, 16'hC1);
    base = n;
    reset = 1'b0; ON = 1'b1; app_enable = 4'b1001;
    for (int k = 0; k < 40; k++) tick();
    chk("t2_count", n - base, 32'd8);
    chk("t2_w0", {14'd0, log_q[base+0]}, 32'h000B0);
    chk("t2_w3", {14'd0, log_q[base+3]}, 32'h000B3);
    chk("t2_w4", {14'd0, log_q[base+4]}, 32'h300C0);
    chk("t2_w5", {14'd0, log_q[base+5]}, 32'h300C1);
    chk("t2_w6", {14'd0, log_q[base+6]}, 32'h000B4);
    chk("t2_w7", {14'd0, log_q[base+7]}, 32'h000B5);

    // Test 3: core backpressure mid-burst on app3.
    do_reset();
    for (int k = 0; k < 6; k++) push(3, 16'hD0 + 16'(k));
    base = n;
    reset = 1'b0; ON = 1'b1; app_enable = 4'b1000;
    wait_rd("t3_start");
    tick();
    chk("t3_rd2", {31'd0, ni_rdEn}, 32'd1);
    tick();
    core_ready = 1'b0;
    #1;
    chk("t3_hold1", {31'd0, ni_rdEn}, 32'd0);
    tick();
    chk("t3_hold2", {31'd0, ni_rdEn}, 32'd0);
    tick();
    chk("t3_hold3", {31'd0, ni_rdEn}, 32'd0);
    chk("t3_hold_dmx", {30'd0, ni_DEMUX}, 32'd3);
    tick();
    core_ready = 1'b1;
    #1;
    chk("t3_rd3", {31'd0, ni_rdEn}, 32'd1);
    tick();
    chk("t3_rd4", {31'd0, ni_rdEn}, 32'd1);
    tick();
    chk("t3_limit", {31'd0, ni_rdEn}, 32'd0);
    tick();
    chk("t3_drain_valid", {31'd0, core_valid}, 32'd0);
    chk("t3_count", n - base, 32'd4);
    chk("t3_w1", {14'd0, log_q[base+1]}, 32'h300D1);
    chk("t3_w3", {14'd0, log_q[base+3]}, 32'h300D3);

    // Test 4: ON dropped right after a read.
    do_reset();
    push(1, 16'hE0); push(1, 16'hE1); push(1, 16'hE2);
    reset = 1'b0; ON = 1'b1; app_enable = 4'b0010;
    wait_rd("t4_start");
    tick();
    chk("t4_rd2", {31'd0, ni_rdEn}, 32'd1);
    tick();
    ON = 1'b0;
    #1;
    chk("t4_off_rden", {31'd0, ni_rdEn}, 32'd0);
    chk("t4_off_word", {14'd0, core_app_id, core_data}, 32'h100E1);
    chk("t4_off_valid", {31'd0, core_valid}, 32'd1);
    tick();
    chk("t4_drain_busy", {31'd0, busy}, 32'd1);
    chk("t4_drain_dmx", {30'd0, ni_DEMUX}, 32'd1);
    tick();
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_dmx", {30'd0, ni_DEMUX}, 32'd2);
    ON = 1'b1;
    tick();
    chk("t4_resume_dmx", {30'd0, ni_DEMUX}, 32'd2);
    chk("t4_resume_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("t4_last_word", {14'd0, log_q[n-1]}, 32'h100E2);

    // Test 5: reset lands on the edge that would return a word.
    do_reset();
    push(2, 16'hF0); push(2, 16'hF1); push(2, 16'hF2);
    reset = 1'b0; ON = 1'b1; app_enable = 4'b0100;
    wait_rd("t5_start");
    base = n;
    reset = 1'b1;
    tick();
    chk("t5_valid", {31'd0, core_valid}, 32'd0);
    chk("t5_dmx", {30'd0, ni_DEMUX}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_data", {16'd0, core_data}, 32'd0);
    tick();
    chk("t5_no_stale", n - base, 32'd0);

    // Test 6: no apps enabled, both from IDLE and from an active scan.
    do_reset();
    push(0, 16'h11); push(1, 16'h22);
    reset = 1'b0; ON = 1'b1; app_enable = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_nord", {31'd0, ni_rdEn}, 32'd0);
    end
    chk("t6_idle", {31'd0, busy}, 32'd0);
    app_enable = 4'b0100;
    tick();
    chk("t6_scan_busy", {31'd0, busy}, 32'd1);
    tick();
    app_enable = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_off_nord", {31'd0, ni_rdEn}, 32'd0);
    end
    chk("t6_off_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
